// File: rtl/tx_arb_pkg.sv
// Shared types for the two-requester UART transmit arbiter.
package tx_arb_pkg;

  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_M = 1'b0,
    GNT_S = 1'b1
  } grant_t;

endpackage

// File: rtl/tx_arb_fair.sv
// Fairness helper: counts consecutive meter grants made while a status byte waits
// and asks for a status grant once MAX_BURST has been reached.
module tx_arb_fair
  import tx_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic m_grant,
  input  logic s_grant,
  input  logic s_valid,
  input  logic in_idle,
  output logic force_s
);

  localparam logic [BURST_W-1:0] BURST_MAX = '1;
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

  logic [BURST_W-1:0] burst_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_reg <= '0;
    end else if (s_grant || (in_idle && !s_valid)) begin
      burst_reg <= '0;
    end else if (m_grant && s_valid && (burst_reg != BURST_MAX)) begin
      burst_reg <= burst_reg + 1'b1;
    end
  end

  assign force_s = (burst_reg == BURST_LIM);

endmodule

// File: rtl/tx_arb.sv
// Meter/status arbiter feeding one byte at a time into the UART valid/ack handshake.
// Optional fairness limit on meter bursts is compiled in with TX_ARB_FAIR_EN.
module tx_arb
  import tx_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] m_data,
  input  logic       m_valid,
  output logic       m_ack,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ack,
  output logic       grant_s
);

  if ((MAX_BURST < 1) || (MAX_BURST > 255)) begin : g_bad_max_burst
    $error("tx_arb: MAX_BURST must lie in 1..255");
  end

  state_t     state_reg, state_next;
  grant_t     grant_reg, grant_next;
  logic [7:0] data_reg, data_next;
  logic       valid_reg, valid_next;
  logic       m_ack_reg, m_ack_next;
  logic       s_ack_reg, s_ack_next;

  logic in_idle;
  logic force_s;
  logic sel_m;
  logic sel_s;

  assign in_idle = (state_reg == IDLE);

`ifdef TX_ARB_FAIR_EN
  logic fair_force;

  tx_arb_fair #(
    .MAX_BURST (MAX_BURST)
  ) u_fair (
    .clk     (clk),
    .rst     (rst),
    .m_grant (in_idle && sel_m),
    .s_grant (in_idle && sel_s),
    .s_valid (s_valid),
    .in_idle (in_idle),
    .force_s (fair_force)
  );

  assign force_s = fair_force && m_valid && s_valid;
`else
  assign force_s = 1'b0;
`endif

  // Meter wins a tie unless the fairness limit has been hit.
  assign sel_s = s_valid && (!m_valid || force_s);
  assign sel_m = m_valid && !sel_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= GNT_M;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      m_ack_reg <= 1'b0;
      s_ack_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      m_ack_reg <= m_ack_next;
      s_ack_reg <= s_ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    m_ack_next = 1'b0;
    s_ack_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (sel_m || sel_s) begin
          data_next  = sel_s ? s_data : m_data;
          grant_next = sel_s ? GNT_S : GNT_M;
          valid_next = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // The ack goes to whoever was granted, even if it has since dropped valid.
        if (tx_ack) begin
          valid_next = 1'b0;
          m_ack_next = (grant_reg == GNT_M);
          s_ack_next = (grant_reg == GNT_S);
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign tx_data  = data_reg;
  assign tx_valid = valid_reg;
  assign m_ack    = m_ack_reg;
  assign s_ack    = s_ack_reg;
  assign grant_s  = (grant_reg == GNT_S);

endmodule

// File: tb/tb_tx_arb.sv
// Self-checking bench for tx_arb: requester models, a UART responder with a
// scoreboard of expected bytes, a vector table and multi-cycle corner sequences.
module tb_tx_arb;

  localparam int MAXB = 3;
`ifdef TX_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ack;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ack;
  logic       grant_s;
  logic       uart_ack = 1'b0;
  logic       spur_ack = 1'b0;

  assign tx_ack = uart_ack | spur_ack;

  tx_arb #(
    .MAX_BURST (MAXB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ack    (m_ack),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ack    (s_ack),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ack   (tx_ack),
    .grant_s  (grant_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       gs;
  } exp_t;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic       mv;
    logic [7:0] md;
    logic       sv;
    logic [7:0] sd;
    int         dly;
    logic [7:0] first;
    logic       first_gs;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  logic [7:0] s_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_dly = 1;
  int done_cnt = 0;
  int m_ack_cnt = 0;
  int s_ack_cnt = 0;
  int last_ack_cyc = 0;
  int gap_base = 32'h3fff_ffff;
  int u_cnt = 0;
  logic u_busy = 1'b0;
  exp_t cur_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: hold the queue head until acked, then present the next byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_ack && s_ack) chk("dual_ack", {m_ack, s_ack}, 2'b01);
      if (m_ack) begin
        m_ack_cnt++;
        if (m_q.size() > 0) m_q.delete(0);
      end
      if (s_ack) begin
        s_ack_cnt++;
        if (s_q.size() > 0) s_q.delete(0);
      end
    end
    m_valid = (m_q.size() > 0);
    m_data  = m_valid ? m_q[0] : 8'h00;
    s_valid = (s_q.size() > 0);
    s_data  = s_valid ? s_q[0] : 8'h00;
  end

  // UART model: takes each byte off the scoreboard, acks after ack_dly cycles.
  always @(negedge clk) begin
    if (rst) begin
      uart_ack = 1'b0;
      u_busy   = 1'b0;
    end else if (uart_ack) begin
      uart_ack = 1'b0;
      chk("tx_valid_after_ack", tx_valid, 0);
      chk("m_ack_pulse", m_ack, !cur_e.gs);
      chk("s_ack_pulse", s_ack, cur_e.gs);
      last_ack_cyc = cyc;
      done_cnt++;
      u_busy = 1'b0;
    end else if (u_busy) begin
      if (u_cnt <= 1) uart_ack = 1'b1;
      else u_cnt--;
    end else if (tx_valid) begin
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        cur_e = exp_q.pop_front();
        $display("tx byte %02h grant_s %0d (expected %02h/%0d)", tx_data, grant_s, cur_e.data, cur_e.gs);
        chk("tx_data", tx_data, cur_e.data);
        chk("grant_s", grant_s, cur_e.gs);
        if (done_cnt >= gap_base) chk("idle_gap", cyc - last_ack_cyc, 2);
      end
      u_busy = 1'b1;
      u_cnt  = ack_dly;
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while ((done_cnt < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", done_cnt >= target, 1);
    repeat (3) @(negedge clk);
  endtask

  // Loads both requesters together; expected order comes from a reference model of the grant rules.
  task automatic run_seq(input bq_t ms, input bq_t ss, input int dly);
    int mi = 0;
    int si = 0;
    int cnt = 0;
    int base = done_cnt;
    int bm = m_ack_cnt;
    int bs = s_ack_cnt;
    exp_t e;
    ack_dly = dly;
    @(posedge clk);
    #1;
    foreach (ms[i]) m_q.push_back(ms[i]);
    foreach (ss[i]) s_q.push_back(ss[i]);
    while ((mi < ms.size()) || (si < ss.size())) begin
      bit mv;
      bit sv;
      mv = (mi < ms.size());
      sv = (si < ss.size());
      if (sv && (!mv || (FAIR && (cnt == MAXB)))) begin
        e.data = ss[si];
        e.gs   = 1'b1;
        si++;
        cnt = 0;
      end else begin
        e.data = ms[mi];
        e.gs   = 1'b0;
        mi++;
        if (sv) cnt = (cnt < 255) ? cnt + 1 : 255;
        else cnt = 0;
      end
      exp_q.push_back(e);
    end
    wait_done(base + ms.size() + ss.size(), 40 * (ms.size() + ss.size() + 1));
    chk("seq_m_acks", m_ack_cnt - bm, ms.size());
    chk("seq_s_acks", s_ack_cnt - bs, ss.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    exp_t e;
    int bm, bs, bd, n;

    vt[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 5, 8'hA5, 1'b0};
    vt[1] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1, 8'h5A, 1'b1};
    vt[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 2, 8'h11, 1'b0};
    vt[3] = '{1'b1, 8'hFF, 1'b1, 8'h00, 1, 8'hFF, 1'b0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 8'h00, 3, 8'h00, 1'b1};
    vt[5] = '{1'b1, 8'h80, 1'b0, 8'h00, 4, 8'h80, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_s_ack", s_ack, 0);
    chk("rst_grant_s", grant_s, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single transactions from IDLE, including same-cycle contention.
    for (int i = 0; i < 6; i++) begin
      ack_dly = vt[i].dly;
      bm = m_ack_cnt;
      bs = s_ack_cnt;
      bd = done_cnt;
      @(posedge clk);
      #1;
      if (vt[i].mv) m_q.push_back(vt[i].md);
      if (vt[i].sv) s_q.push_back(vt[i].sd);
      e.data = vt[i].first;
      e.gs   = vt[i].first_gs;
      exp_q.push_back(e);
      if (vt[i].mv && vt[i].sv) begin
        e.data = vt[i].sd;
        e.gs   = 1'b1;
        exp_q.push_back(e);
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("req_latency", tx_valid, 1);
      wait_done(bd + int'(vt[i].mv) + int'(vt[i].sv), 100);
      chk("vec_m_acks", m_ack_cnt - bm, vt[i].mv);
      chk("vec_s_acks", s_ack_cnt - bs, vt[i].sv);
    end

    // Simultaneous rise: M then S with exactly two idle cycles between.
    gap_base = done_cnt + 1;
    run_seq('{8'h33}, '{8'h44}, 2);
    gap_base = 32'h3fff_ffff;

    // M held continuously with one S pending.
    gap_base = done_cnt + 1;
    run_seq('{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66}, '{8'h5A}, 1);
    gap_base = 32'h3fff_ffff;

    // Fairness pattern (strict order when the limit is not compiled in).
    run_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, '{8'hEE, 8'hEE}, 1);

    // Spurious tx_ack while IDLE.
    bm = m_ack_cnt;
    bs = s_ack_cnt;
    bd = done_cnt;
    @(negedge clk);
    #1 spur_ack = 1'b1;
    @(negedge clk);
    #1 spur_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("spur_idle_valid", tx_valid, 0);
    chk("spur_idle_m_acks", m_ack_cnt - bm, 0);
    chk("spur_idle_s_acks", s_ack_cnt - bs, 0);

    // Spurious tx_ack during RELEASE.
    ack_dly = 2;
    @(posedge clk);
    #1;
    m_q.push_back(8'h77);
    m_q.push_back(8'h78);
    e.gs = 1'b0;
    e.data = 8'h77;
    exp_q.push_back(e);
    e.data = 8'h78;
    exp_q.push_back(e);
    n = 0;
    while (!m_ack && (n < 100)) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("release_seen", m_ack, 1);
    spur_ack = 1'b1;
    @(negedge clk);
    #1 spur_ack = 1'b0;
    wait_done(bd + 2, 100);
    chk("spur_rel_m_acks", m_ack_cnt - bm, 2);
    chk("spur_rel_s_acks", s_ack_cnt - bs, 0);

    // Reset while BUSY: byte abandoned, then re-sent once.
    ack_dly = 20;
    bm = m_ack_cnt;
    bs = s_ack_cnt;
    bd = done_cnt;
    @(posedge clk);
    #1;
    m_q.push_back(8'h3C);
    e.data = 8'h3C;
    e.gs   = 1'b0;
    exp_q.push_back(e);
    n = 0;
    while (!tx_valid && (n < 20)) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("busy_before_rst", tx_valid, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_grant_s", grant_s, 0);
    chk("mid_rst_m_ack", m_ack, 0);
    chk("mid_rst_s_ack", s_ack, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    ack_dly = 2;
    exp_q.push_back(e);
    wait_done(bd + 1, 100);
    repeat (5) @(negedge clk);
    chk("rst_resend_m_acks", m_ack_cnt - bm, 1);
    chk("rst_resend_s_acks", s_ack_cnt - bs, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
